vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port synchronous pixel RAM (160x120 RGB444 framebuffer) among three requesters.
//  - Display fetch path: driven by the VGA timing block's p_tick/video_on/x/y. Highest priority.
//  - Bulk clear engine.
//  - Game-logic pixel writer with a valid/ready handshake.
//  Produces the registered rgb output plus sync signals delayed to match it.
// PARAMETERS
//  FB_W         160  framebuffer width in stored pixels
//  FB_H         120  framebuffer height in stored pixels
//  SCALE_SHIFT  2    screen-to-framebuffer shift (4x4 screen pixels per stored pixel)
//  PIX_W        12   pixel width (RGB444)
//  ADDR_W       15   RAM address width (FB_W*FB_H <= 2**ADDR_W)
// PORTS
//  clk_100MHz   in   1       system clock
//  reset        in   1       synchronous, active-high
//  p_tick       in   1       1-in-4 pixel tick from timing block
//  video_on     in   1       display-area flag
//  x, y         in   10 ea   screen pixel counters
//  hsync_in     in   1       raw sync from timing block
//  vsync_in     in   1       raw sync from timing block
//  wr_valid     in   1       writer request
//  wr_ready     out  1       writer may transfer this cycle
//  wr_x         in   8       writer pixel x coordinate
//  wr_y         in   7       writer pixel y coordinate
//  wr_data      in   PIX_W   writer pixel value
//  clear_req    in   1       pulse: start full-frame clear
//  clear_color  in   PIX_W   fill value; sampled when clear_req is accepted
//  clear_busy   out  1       clear in progress
//  wr_oob       out  1       1-cycle pulse: accepted write had out-of-range coordinates and was dropped
//  ram_en       out  1       RAM port enable (combinational)
//  ram_we       out  1       RAM port write enable (combinational)
//  ram_addr     out  ADDR_W  RAM address (combinational)
//  ram_wdata    out  PIX_W   RAM write data (combinational)
//  ram_rdata    in   PIX_W   read data, valid the cycle after a read
//  rgb          out  PIX_W   pixel to DAC, registered
//  hsync_out    out  1       sync aligned with rgb, registered
//  vsync_out    out  1       sync aligned with rgb, registered
// BEHAVIOUR
//  Reset values: rgb=0, hsync_out=0, vsync_out=0, clear_busy=0, wr_oob=0. Reset aborts any clear in progress; RAM contents are then undefined.
//  Slot ownership is decided every cycle with fixed priority: display > clear > writer.
//  Display slot:
//  - Taken when p_tick & video_on & (x>>2)<FB_W & (y>>2)<FB_H.
//  - Drives ram_en=1, ram_we=0, ram_addr=(y>>2)*FB_W+(x>>2). Address arithmetic is ADDR_W wide with no truncation.
//  Display latency: p_tick in cycle T, data returns in T+1, rgb updates at the edge ending T+1 (visible from T+2). rgb holds until the next p_tick.
//  Black output: p_tick with video_on=0, or with out-of-range coords (e.g. y=480..499), loads rgb=0 on the same schedule and issues no read. That slot is free for the other requesters.
//  Sync alignment: hsync_in/vsync_in are sampled at each p_tick and pass through a 2-stage pipeline, so they appear together with the matching rgb.
//  Clear engine:
//  - clear_req accepted only when clear_busy=0. A request while busy is ignored.
//  - On accept: clear_busy=1 next cycle, clear_color latched, address counter=0.
//  - Each free slot writes clear_color to the counter address, then increments it.
//  - After address FB_W*FB_H-1 is written, clear_busy=0 on the next cycle.
//  Writer:
//  - wr_ready = ~display_slot & ~clear_busy & ~clear_req.
//  - Transfer occurs on wr_valid & wr_ready. It writes wr_data to wr_y*FB_W+wr_x in the same cycle.
//  - If wr_x>=FB_W or wr_y>=FB_H, the transfer completes but no RAM access is made, and wr_oob pulses the next cycle.
//  - Writer inputs must stay stable while wr_valid=1 and wr_ready=0.
//  Simultaneous events:
//  - clear_req and wr_valid in the same cycle: clear wins, wr_ready=0.
//  - A display slot during a clear: the clear stalls for that cycle and its counter holds.
//  Idle: ram_en=0 whenever no requester owns the slot.
// STRUCTURE
//  Package vga_fb_pkg: FB_W, FB_H, PIX_W, ADDR_W, SCALE_SHIFT, COLOR_BLACK, and function fb_addr(x,y).
//  Sub-module fb_clear_engine: holds busy flag, latched colour, and address counter. Inputs: start, grant. Outputs: req, addr, data, busy.
//  Top level: slot arbitration, display read pipeline, sync delay pipeline.
// TESTING
//  1. Preload RAM[fb_addr(3,2)]=12'hF0A; drive x=12, y=8, video_on=1, p_tick -> ram_addr=323 in cycle T; rgb=12'hF0A from T+2.
//  2. video_on=1, y=480, p_tick -> no ram_en; rgb=0 at T+2. A writer held valid in that cycle gets wr_ready=1.
//  3. Writer valid for (159,119,12'h123) with p_tick&video_on asserted -> wr_ready=0 in that cycle; write to addr 19199 on the next free cycle.
//  4. clear_req with clear_color=12'h00F, display idle -> clear_busy high for exactly 19200 cycles; every address reads 12'h00F; a second clear_req mid-clear is ignored.
//  5. Writer (160,5) accepted -> no RAM write; wr_oob=1 for one cycle. clear_req+wr_valid in the same cycle -> wr_ready=0 and the clear starts.
//  6. Assert reset mid-clear at address 5000 -> next cycle clear_busy=0, rgb=0, sync outputs=0; a new clear_req restarts at address 0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// ---------------------------------------------------------------------------
// vga_fb_pkg: framebuffer geometry, pixel format and address helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_fb_pkg;

  localparam int unsigned FB_W        = 160;
  localparam int unsigned FB_H        = 120;
  localparam int unsigned FB_SIZE     = FB_W * FB_H;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned PIX_W       = 12;
  localparam int unsigned ADDR_W      = 15;

  localparam logic [PIX_W-1:0] COLOR_BLACK = '0;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_DISP  = 2'd1,
    SLOT_CLEAR = 2'd2,
    SLOT_WRITE = 2'd3
  } slot_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Row-major linear address, computed at full RAM address width.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] px,
                                                input logic [ADDR_W-1:0] py);
    return py * ADDR_W'(FB_W) + px;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_clear_engine.sv
// ---------------------------------------------------------------------------
// fb_clear_engine: sequential full-frame fill, one word per granted slot. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_clear_engine
  import vga_fb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              grant_i,
  input  logic [PIX_W-1:0]  color_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  data_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  clr_state_e        state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  color_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLR_IDLE;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      color_q <= COLOR_BLACK;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (start_i) begin
            state_q <= CLR_RUN;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            color_q <= color_i;
          end
        end
        CLR_RUN: begin
          // Counter only advances on slots actually granted to the clear.
          if (grant_i) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= CLR_IDLE;
              busy_q  <= 1'b0;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= CLR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_o  = busy_q;
  assign busy_o = busy_q;
  assign addr_o = addr_q;
  assign data_o = color_q;

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter: display/clear/writer sharing of one framebuffer RAM port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic              wr_oob,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  logic [9:0]        w_fx;
  logic [9:0]        w_fy;
  logic              w_disp_slot;
  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_clr_req;
  logic              w_clr_grant;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [PIX_W-1:0]  w_clr_data;
  logic              w_wr_fire;
  logic              w_wr_inb;
  logic [ADDR_W-1:0] w_wr_addr;
  slot_e             w_slot;

  assign w_fx        = x >> SCALE_SHIFT;
  assign w_fy        = y >> SCALE_SHIFT;
  assign w_disp_slot = p_tick & video_on & (w_fx < 10'(FB_W)) & (w_fy < 10'(FB_H));
  assign w_disp_addr = fb_addr(ADDR_W'(w_fx), ADDR_W'(w_fy));

  assign w_clr_grant = w_clr_req & ~w_disp_slot;

  fb_clear_engine u_clear (
    .clk_i   (clk_100MHz),
    .rst_i   (reset),
    .start_i (clear_req),
    .grant_i (w_clr_grant),
    .color_i (clear_color),
    .req_o   (w_clr_req),
    .addr_o  (w_clr_addr),
    .data_o  (w_clr_data),
    .busy_o  (clear_busy)
  );

  // A pending clear_req blocks the writer even before the engine goes busy.
  assign wr_ready  = ~w_disp_slot & ~clear_busy & ~clear_req;
  assign w_wr_fire = wr_valid & wr_ready;
  assign w_wr_inb  = (wr_x < 8'(FB_W)) & (wr_y < 7'(FB_H));
  assign w_wr_addr = fb_addr(ADDR_W'(wr_x), ADDR_W'(wr_y));

  always_comb begin
    w_slot = SLOT_IDLE;
    if (w_disp_slot)             w_slot = SLOT_DISP;
    else if (w_clr_req)          w_slot = SLOT_CLEAR;
    else if (w_wr_fire & w_wr_inb) w_slot = SLOT_WRITE;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = COLOR_BLACK;
    case (w_slot)
      SLOT_DISP: begin
        ram_en   = 1'b1;
        ram_addr = w_disp_addr;
      end
      SLOT_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = w_clr_addr;
        ram_wdata = w_clr_data;
      end
      SLOT_WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = w_wr_addr;
        ram_wdata = wr_data;
      end
      default: ;
    endcase
  end

  logic             tick_q;
  logic             rd_q;
  logic             hs_s1_q;
  logic             vs_s1_q;
  logic [PIX_W-1:0] rgb_q;
  logic [PIX_W-1:0] rgb_d;
  logic             hsync_q;
  logic             vsync_q;
  logic             wr_oob_q;
  logic             wr_oob_d;

  // Ticks without a read (blanking / off-frame) still produce a black pixel.
  assign rgb_d    = rd_q ? ram_rdata : COLOR_BLACK;
  assign wr_oob_d = w_wr_fire & ~w_wr_inb;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tick_q   <= 1'b0;
      rd_q     <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      rgb_q    <= COLOR_BLACK;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      wr_oob_q <= 1'b0;
    end else begin
      tick_q   <= p_tick;
      rd_q     <= w_disp_slot;
      wr_oob_q <= wr_oob_d;
      if (p_tick) begin
        hs_s1_q <= hsync_in;
        vs_s1_q <= vsync_in;
      end
      if (tick_q) begin
        rgb_q   <= rgb_d;
        hsync_q <= hs_s1_q;
        vsync_q <= vs_s1_q;
      end
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign wr_oob    = wr_oob_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter: directed stimulus with queue-based scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_fb_arbiter;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic        clear_req = 1'b0;
  logic [11:0] clear_color = '0;
  logic        clear_busy;
  logic        wr_oob;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  vga_fb_arbiter dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .clear_busy (clear_busy),
    .wr_oob     (wr_oob),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  logic [11:0] mem [0:19199];

  always @(posedge clk_100MHz) begin
    if (ram_en) begin
      if (ram_we) begin
        if (ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= (ram_addr < 15'd19200) ? mem[ram_addr] : 12'h000;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int oob_pending = 0;
  logic [26:0] exp_wr_q [$];
  logic [13:0] exp_pix_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
    p_tick    = 1'b0;
    clear_req = 1'b0;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic neg();
    @(negedge clk_100MHz);
  endtask

  task automatic do_tick(input logic [9:0] tx, input logic [9:0] ty, input logic von,
                         input logic hs, input logic vs, input logic [11:0] er);
    step();
    p_tick   = 1'b1;
    x        = tx;
    y        = ty;
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    exp_pix_q.push_back({er, hs, vs});
  endtask

  task automatic push_clear(input logic [11:0] col);
    for (int i = 0; i < 19200; i++) exp_wr_q.push_back({15'(i), col});
  endtask

  // Monitor: RAM writes, pixel/sync results two cycles after each tick, oob pulses.
  initial begin
    logic [1:0]  hist;
    logic [26:0] ew;
    logic [13:0] ep;
    hist = 2'b00;
    forever begin
      @(negedge clk_100MHz);
      if (ram_en && ram_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ram_write: unexpected write addr=%0d data=0x%0h", ram_addr, ram_wdata);
        end else begin
          ew = exp_wr_q.pop_front();
          check("ram_write", {5'd0, ram_addr, ram_wdata}, {5'd0, ew});
        end
      end
      if (hist[1]) begin
        if (exp_pix_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rgb_sync: no expected pixel, actual rgb=0x%0h", rgb);
        end else begin
          ep = exp_pix_q.pop_front();
          check("rgb_sync", {18'd0, rgb, hsync_out, vsync_out}, {18'd0, ep});
        end
      end
      hist = {hist[0], p_tick & ~reset};
      if (wr_oob) begin
        check("wr_oob_expected", {31'd0, oob_pending != 0}, 32'd1);
        if (oob_pending != 0) oob_pending--;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int g;
    mem[323]   = 12'hF0A;
    mem[19199] = 12'hABC;
    mem[0]     = 12'h777;

    step(); step(); step();
    reset = 1'b0;
    neg();
    check("reset_rgb", {20'd0, rgb}, 32'd0);
    check("reset_hsync", {31'd0, hsync_out}, 32'd0);
    check("reset_vsync", {31'd0, vsync_out}, 32'd0);
    check("reset_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("reset_wr_oob", {31'd0, wr_oob}, 32'd0);
    check("idle_ram_en", {31'd0, ram_en}, 32'd0);

    // Display fetch: (12,8) -> stored (3,2) -> 323; far corner -> 19199.
    do_tick(10'd12, 10'd8, 1'b1, 1'b1, 1'b0, 12'hF0A);
    neg();
    check("disp_ram_en", {31'd0, ram_en}, 32'd1);
    check("disp_ram_we", {31'd0, ram_we}, 32'd0);
    check("disp_addr_323", {17'd0, ram_addr}, 32'd323);
    check("disp_blocks_writer", {31'd0, wr_ready}, 32'd0);
    idle(3);
    do_tick(10'd639, 10'd479, 1'b1, 1'b0, 1'b1, 12'hABC);
    neg();
    check("disp_addr_19199", {17'd0, ram_addr}, 32'd19199);
    idle(3);
    neg();
    check("rgb_hold", {20'd0, rgb}, 32'h0ABC);

    // Off-frame tick frees the slot for the writer.
    do_tick(10'd0, 10'd480, 1'b1, 1'b1, 1'b1, 12'h000);
    wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd10; wr_data = 12'h5A5;
    exp_wr_q.push_back({15'd1610, 12'h5A5});
    neg();
    check("offframe_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("offframe_write_we", {31'd0, ram_we}, 32'd1);
    check("offframe_write_addr", {17'd0, ram_addr}, 32'd1610);
    step();
    wr_valid = 1'b0;
    idle(2);
    do_tick(10'd12, 10'd8, 1'b0, 1'b0, 1'b0, 12'h000);
    neg();
    check("blank_no_ram_en", {31'd0, ram_en}, 32'd0);
    idle(3);

    // Writer stalled by display, completes next free cycle.
    do_tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h777);
    wr_valid = 1'b1; wr_x = 8'd159; wr_y = 7'd119; wr_data = 12'h123;
    exp_wr_q.push_back({15'd19199, 12'h123});
    neg();
    check("stall_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("stall_ram_we", {31'd0, ram_we}, 32'd0);
    check("stall_disp_addr", {17'd0, ram_addr}, 32'd0);
    step();
    neg();
    check("after_stall_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("after_stall_addr", {17'd0, ram_addr}, 32'd19199);
    step();
    wr_valid = 1'b0;
    idle(2);

    // Out-of-range writes: accepted, dropped, one-cycle wr_oob.
    for (int i = 0; i < 2; i++) begin
      step();
      wr_valid = 1'b1;
      wr_x = (i == 0) ? 8'd160 : 8'd3;
      wr_y = (i == 0) ? 7'd5 : 7'd120;
      oob_pending++;
      neg();
      check("oob_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("oob_no_ram_en", {31'd0, ram_en}, 32'd0);
      step();
      wr_valid = 1'b0;
      neg();
      check("oob_pulse", {31'd0, wr_oob}, 32'd1);
      step();
      neg();
      check("oob_pulse_end", {31'd0, wr_oob}, 32'd0);
    end

    // Clear wins over a simultaneous writer, which then waits out the clear.
    step();
    clear_req = 1'b1; clear_color = 12'h00F;
    wr_valid = 1'b1; wr_x = 8'd20; wr_y = 7'd20; wr_data = 12'h321;
    push_clear(12'h00F);
    exp_wr_q.push_back({15'd3220, 12'h321});
    neg();
    check("clr_vs_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("clr_accept_no_ram", {31'd0, ram_en}, 32'd0);
    check("clr_accept_busy", {31'd0, clear_busy}, 32'd0);
    cnt = 0;
    g = 0;
    while (g < 25000) begin
      step();
      if (cnt == 100) begin
        clear_req = 1'b1;
        clear_color = 12'hFFF;
      end
      neg();
      g++;
      if (!clear_busy) break;
      cnt++;
      if (cnt == 50) check("busy_wr_ready", {31'd0, wr_ready}, 32'd0);
    end
    check("clear_busy_cycles", cnt, 32'd19200);
    check("post_clear_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0;
    clear_color = 12'h000;
    do_tick(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 12'h00F);
    idle(3);
    do_tick(10'd320, 10'd240, 1'b1, 1'b1, 1'b0, 12'h00F);
    idle(3);
    do_tick(10'd80, 10'd80, 1'b1, 1'b0, 1'b1, 12'h321);
    idle(3);

    // Second clear: display stalls it, then reset aborts it near address 5000.
    step();
    clear_req = 1'b1; clear_color = 12'h0F0;
    push_clear(12'h0F0);
    idle(10);
    do_tick(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h0F0);
    neg();
    check("clr_stall_we", {31'd0, ram_we}, 32'd0);
    check("clr_stall_addr", {17'd0, ram_addr}, 32'd0);
    check("clr_stall_busy", {31'd0, clear_busy}, 32'd1);
    g = 0;
    do begin
      step();
      neg();
      g++;
    end while (!(ram_we && ram_addr == 15'd5000) && g < 10000);
    check("reach_addr_5000", {17'd0, ram_addr}, 32'd5000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_wr_q.delete();
    neg();
    check("abort_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("abort_rgb", {20'd0, rgb}, 32'd0);
    check("abort_hsync", {31'd0, hsync_out}, 32'd0);
    check("abort_vsync", {31'd0, vsync_out}, 32'd0);
    check("abort_ram_en", {31'd0, ram_en}, 32'd0);

    step();
    clear_req = 1'b1; clear_color = 12'h0AA;
    push_clear(12'h0AA);
    step();
    neg();
    check("restart_busy", {31'd0, clear_busy}, 32'd1);
    check("restart_addr0", {17'd0, ram_addr}, 32'd0);
    check("restart_data", {20'd0, ram_wdata}, 32'h00AA);
    g = 0;
    while (clear_busy && g < 20000) begin
      step();
      neg();
      g++;
    end
    check("restart_done", {31'd0, clear_busy}, 32'd0);

    idle(3);
    neg();
    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    check("pix_queue_empty", exp_pix_q.size(), 32'd0);
    check("oob_pending_zero", oob_pending, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
